// File: rtl/mem_responder.sv
// Multicycle memory responder: word-addressed local array serviced after LATENCY wait states.
// Optional misaligned-access detection is enabled by defining MEM_RESP_ALIGN_CHECK_EN.
module mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LOAD_CNT = CW'(LATENCY);
    localparam logic [CW-1:0] ONE      = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [31:0]   addrQ;
    logic [31:0]   wdQ;
    logic          weQ;
    logic [31:0]   mem [DEPTH];

    logic          direct;
    logic          doAccess;
    logic          accWe;
    logic [31:0]   accAddr;
    logic [31:0]   accWd;
    logic [AW-1:0] accIdx;
    logic          misaligned;
    logic          doWrite;
    logic [31:0]   rdNext;
    logic          unusedAddrBits;

    // With zero latency the access happens on the accepting edge, so the live inputs feed it.
    always_comb begin
        direct   = (state == IDLE) && req && (LATENCY == 0);
        doAccess = direct || ((state == WAIT) && (count == ONE));
        accWe    = direct ? we   : weQ;
        accAddr  = direct ? addr : addrQ;
        accWd    = direct ? wd   : wdQ;
        accIdx   = accAddr[AW+1:2];
`ifdef MEM_RESP_ALIGN_CHECK_EN
        misaligned = (accAddr[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        doWrite  = doAccess && accWe && !misaligned;
        if (misaligned) begin
            rdNext = 32'd0;
        end else if (accWe) begin
            rdNext = accWd;
        end else begin
            rdNext = mem[accIdx];
        end
    end

    assign unusedAddrBits = ^{accAddr[31:AW+2], accAddr[1:0]};

    // Storage is not reset; a store landing on an edge where reset is high is dropped.
    always_ff @(posedge clk) begin
        if (doWrite && !reset) begin
            mem[accIdx] <= accWd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            addrQ <= 32'd0;
            wdQ   <= 32'd0;
            weQ   <= 1'b0;
            rd    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addrQ <= addr;
                        wdQ   <= wd;
                        weQ   <= we;
                        count <= LOAD_CNT;
                        state <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (count == ONE) begin
                        state <= RESP;
                    end else begin
                        count <= count - ONE;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (doAccess) begin
                rd <= rdNext;
            end
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);

`ifdef MEM_RESP_ALIGN_CHECK_EN
    logic errQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errQ <= 1'b0;
        end else if (doAccess) begin
            errQ <= misaligned;
        end
    end

    assign err = ready & errQ;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a LATENCY=2 instance driven from a vector table
// plus hand sequences, and a LATENCY=0 instance for the back-to-back corner case.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wd, rd;
    logic        ready, busy, err;
    logic        req0, we0;
    logic [31:0] addr0, wd0, rd0;
    logic        ready0, busy0, err0;

    int errors = 0;
    int checks = 0;

`ifdef MEM_RESP_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    vec_t vecs[10];

    mem_responder #(.DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wd(wd),
        .rd(rd), .ready(ready), .busy(busy), .err(err)
    );

    mem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wd(wd0),
        .rd(rd0), .ready(ready0), .busy(busy0), .err(err0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Run one transaction on the LATENCY=2 instance, scrambling inputs once it is accepted.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 output int lat, output logic [31:0] gotRd,
                                 output logic gotErr, output logic busyOk);
        @(negedge clk);
        we = w; addr = a; wd = d; req = 1'b1;
        @(posedge clk);
        lat = 0;
        busyOk = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!busy) busyOk = 1'b0;
            if (lat == 1) begin
                req = 1'b0; we = ~w; addr = ~a; wd = ~d;
            end
        end while (!ready && lat < 20);
        gotRd = rd;
        gotErr = err;
        @(negedge clk);
        if (busy || ready) busyOk = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] gotRd;
        logic        gotErr;
        logic        busyOk;

        vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0104, 32'h1111_1111, 32'h1111_1111, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1111_1111, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_0020, 32'h0,         32'h0,         1'b0};
        vecs[7] = '{1'b1, 32'h0000_000A, 32'hCAFE_F00D, ALIGN ? 32'h0 : 32'hCAFE_F00D, ALIGN};
        vecs[8] = '{1'b0, 32'h0000_0008, 32'h0,         ALIGN ? 32'hDEAD_BEEF : 32'hCAFE_F00D, 1'b0};
        vecs[9] = '{1'b0, 32'h0000_0104, 32'h0,         32'h1111_1111, 1'b0};

        reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = 32'd0; wd = 32'd0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wd0 = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_rd",     rd,             32'd0);
        checkOutput("reset_ready",  32'(ready),     32'd0);
        checkOutput("reset_busy",   32'(busy),      32'd0);
        checkOutput("reset_err",    32'(err),       32'd0);
        checkOutput("reset0_ready", 32'(ready0),    32'd0);
        checkOutput("reset0_busy",  32'(busy0),     32'd0);
        reset = 1'b0;
        $display("[TB] reset released");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].w, vecs[i].a, vecs[i].d, lat, gotRd, gotErr, busyOk);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat),    32'd3);
            checkOutput($sformatf("vec%0d_rd", i),      gotRd,       vecs[i].expRd);
            checkOutput($sformatf("vec%0d_err", i),     32'(gotErr), 32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d_busy", i),    32'(busyOk), 32'd1);
        end

        // req toggled and addr/wd changed during WAIT must not disturb the captured store.
        @(negedge clk);
        we = 1'b1; addr = 32'h30; wd = 32'h1234_5678; req = 1'b1;
        @(negedge clk);
        checkOutput("stab_busy1", 32'(busy), 32'd1);
        req = 1'b0; addr = 32'h34; wd = 32'h0; we = 1'b0;
        @(negedge clk);
        checkOutput("stab_noready", 32'(ready), 32'd0);
        req = 1'b1; addr = 32'h38;
        @(negedge clk);
        checkOutput("stab_ready", 32'(ready), 32'd1);
        checkOutput("stab_rd",    rd,         32'h1234_5678);
        req = 1'b0;
        @(negedge clk);
        checkOutput("stab_idle_ready", 32'(ready), 32'd0);
        @(negedge clk);
        checkOutput("stab_no_extra", 32'(ready), 32'd0);
        checkOutput("stab_no_busy",  32'(busy),  32'd0);
        applyStimulus(1'b0, 32'h30, 32'h0, lat, gotRd, gotErr, busyOk);
        checkOutput("stab_readback", gotRd, 32'h1234_5678);

        // Reset during WAIT of a store discards it and clears outputs at once.
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wd = 32'hDEAD_DEAD; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        checkOutput("rst_busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_busy",  32'(busy),  32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_rd",    rd,         32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h20, 32'h0, lat, gotRd, gotErr, busyOk);
        checkOutput("rst_discard_rd",  gotRd,    32'h0);
        checkOutput("rst_discard_lat", 32'(lat), 32'd3);

        // Zero-latency instance: req held through ready is accepted only in the next IDLE.
        @(negedge clk);
        we0 = 1'b1; addr0 = 32'h08; wd0 = 32'h0BAD_F00D; req0 = 1'b1;
        @(negedge clk);
        checkOutput("l0_ready1", 32'(ready0), 32'd1);
        checkOutput("l0_rd1",    rd0,         32'h0BAD_F00D);
        checkOutput("l0_busy1",  32'(busy0),  32'd1);
        we0 = 1'b0; wd0 = 32'h0;
        @(negedge clk);
        checkOutput("l0_idle_ready", 32'(ready0), 32'd0);
        checkOutput("l0_idle_busy",  32'(busy0),  32'd0);
        @(negedge clk);
        checkOutput("l0_ready2", 32'(ready0), 32'd1);
        checkOutput("l0_rd2",    rd0,         32'h0BAD_F00D);
        checkOutput("l0_err2",   32'(err0),   32'd0);
        req0 = 1'b0;
        @(negedge clk);
        checkOutput("l0_done_ready", 32'(ready0), 32'd0);
        checkOutput("l0_done_busy",  32'(busy0),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
